// File: rtl/common_freelist_alloc_1a1r_if.sv
// Bundle between the free-tag allocator, its consumer and the external free-list FIFO.
// Ports: alloc_* (tag offer/take), release_* (tag return), fifo_* (FIFO push/pop/status),
//        free_count / err_release / err_sticky (status). "slave" is the allocator side.
interface common_freelist_alloc_1a1r_if #(
  parameter int TAG_WIDTH = 6,
  parameter int CNT_WIDTH = 5
);
  logic                 alloc_valid;
  logic [TAG_WIDTH-1:0] alloc_tag;
  logic                 alloc_take;
  logic                 release_valid;
  logic [TAG_WIDTH-1:0] release_tag;
  logic [TAG_WIDTH-1:0] fifo_din;
  logic                 fifo_wen;
  logic [TAG_WIDTH-1:0] fifo_dout;
  logic                 fifo_ren;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [CNT_WIDTH-1:0] free_count;
  logic                 err_release;
  logic                 err_sticky;

  modport slave (
    output alloc_valid, alloc_tag, fifo_din, fifo_wen, fifo_ren,
           free_count, err_release, err_sticky,
    input  alloc_take, release_valid, release_tag, fifo_dout, fifo_empty, fifo_full
  );

  modport master (
    input  alloc_valid, alloc_tag, fifo_din, fifo_wen, fifo_ren,
           free_count, err_release, err_sticky,
    output alloc_take, release_valid, release_tag, fifo_dout, fifo_empty, fifo_full
  );
endinterface

// File: rtl/common_freelist_alloc_1a1r.sv
// Free-tag allocator: prefetches the free-list FIFO head into a registered stage and returns released tags to the FIFO tail.
// Latency: tag offered one edge after its FIFO pop; a released tag reaches alloc_tag no sooner than two edges after release.
// Backpressure: consumer stalls by holding alloc_take low; illegal releases (out of range, not in use, FIFO full) are dropped and flagged.
// Ports: clk, resetn (async, active-low); bus (slave modport) carries alloc_*, release_*, fifo_*, free_count, err_release, err_sticky.
module common_freelist_alloc_1a1r #(
  parameter int TAG_WIDTH = 6,
  parameter int TAG_COUNT = 16,
  parameter int CNT_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         resetn,
  common_freelist_alloc_1a1r_if.slave  bus
);

  logic                 stage_valid;
  logic [TAG_WIDTH-1:0] stage_tag;
  logic [TAG_COUNT-1:0] in_use;
  logic [CNT_WIDTH-1:0] free_count;
  logic                 err_release;
  logic                 err_sticky;

  logic take;
  logic pop;
  logic rel_in_use;
  logic rel_legal;
  logic rel_reject;

  assign take = bus.alloc_take & stage_valid;
  // Refill the stage whenever it is empty or being emptied this cycle.
  assign pop  = (~stage_valid | take) & ~bus.fifo_empty;

  // Only tags below TAG_COUNT match an entry, so out-of-range tags read as not in use.
  always_comb begin
    rel_in_use = 1'b0;
    for (int i = 0; i < TAG_COUNT; i++) begin
      if (bus.release_tag == TAG_WIDTH'(i)) rel_in_use = in_use[i];
    end
  end

  // in_use is the registered value, so a tag taken this same cycle cannot be released yet.
  assign rel_legal  = bus.release_valid & rel_in_use & ~bus.fifo_full;
  assign rel_reject = bus.release_valid & ~rel_legal;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stage_valid <= 1'b0;
      stage_tag   <= '0;
      in_use      <= '0;
      free_count  <= CNT_WIDTH'(TAG_COUNT);
      err_release <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      if (pop) begin
        stage_valid <= 1'b1;
        stage_tag   <= bus.fifo_dout;
      end else if (take) begin
        stage_valid <= 1'b0;
      end

      for (int i = 0; i < TAG_COUNT; i++) begin
        if (take && stage_tag == TAG_WIDTH'(i)) begin
          in_use[i] <= 1'b1;
        end else if (rel_legal && bus.release_tag == TAG_WIDTH'(i)) begin
          in_use[i] <= 1'b0;
        end
      end

      case ({rel_legal, take})
        2'b10:   free_count <= free_count + CNT_WIDTH'(1);
        2'b01:   free_count <= free_count - CNT_WIDTH'(1);
        default: free_count <= free_count;
      endcase

      err_release <= rel_reject;
      err_sticky  <= err_sticky | rel_reject;
    end
  end

  assign bus.alloc_valid = stage_valid;
  assign bus.alloc_tag   = stage_valid ? stage_tag : '0;
  assign bus.fifo_din    = bus.release_tag;
  assign bus.fifo_wen    = rel_legal;
  assign bus.fifo_ren    = pop;
  assign bus.free_count  = free_count;
  assign bus.err_release = err_release;
  assign bus.err_sticky  = err_sticky;

endmodule

// File: tb/tb_common_freelist_alloc_1a1r.sv
module tb_common_freelist_alloc_1a1r;
  localparam int TW = 6;
  localparam int TC = 16;
  localparam int CW = 5;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  common_freelist_alloc_1a1r_if #(.TAG_WIDTH(TW), .CNT_WIDTH(CW)) bus ();

  common_freelist_alloc_1a1r #(.TAG_WIDTH(TW), .TAG_COUNT(TC), .CNT_WIDTH(CW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // External free-list FIFO: preloaded with 0..TC-1 on reset.
  logic [TW-1:0] fq[$];
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fq.delete();
      for (int i = 0; i < TC; i++) fq.push_back(TW'(i));
    end else begin
      if (bus.fifo_ren && fq.size() > 0) void'(fq.pop_front());
      if (bus.fifo_wen && fq.size() < TC) fq.push_back(bus.fifo_din);
    end
    bus.fifo_dout  <= (fq.size() > 0) ? fq[0] : '0;
    bus.fifo_empty <= (fq.size() == 0);
    bus.fifo_full  <= (fq.size() == TC);
  end

  // Reference model: ordered list of all free tags, each tagged with the first edge
  // after which it may be offered; the head is offered once that edge has passed.
  typedef struct {
    logic [TW-1:0] tag;
    int            earliest;
  } ent_t;
  ent_t mq[$];
  bit   m_vis;
  bit   m_err;
  bit   m_sticky;
  bit   m_used[TC];
  int   edge_n;

  function automatic bit m_rel_ok();
    int t;
    t = int'(bus.release_tag);
    if (!bus.release_valid || t >= TC) return 1'b0;
    if (!m_used[t]) return 1'b0;
    return (mq.size() - int'(m_vis)) < TC;
  endfunction

  always @(posedge clk or negedge resetn) begin : model
    bit   rel_ok;
    bit   tk;
    ent_t e;
    if (!resetn) begin
      mq.delete();
      for (int i = 0; i < TC; i++) begin
        e.tag = TW'(i);
        e.earliest = 1;
        mq.push_back(e);
        m_used[i] = 1'b0;
      end
      m_vis = 1'b0; m_err = 1'b0; m_sticky = 1'b0; edge_n = 0;
    end else begin
      edge_n++;
      rel_ok = m_rel_ok();
      tk = bus.alloc_take && m_vis;
      m_err = bus.release_valid && !rel_ok;
      m_sticky = m_sticky || m_err;
      if (tk) begin
        m_used[int'(mq[0].tag)] = 1'b1;
        void'(mq.pop_front());
        m_vis = 1'b0;
      end
      if (rel_ok) begin
        m_used[int'(bus.release_tag)] = 1'b0;
        e.tag = bus.release_tag;
        e.earliest = edge_n + 1;
        mq.push_back(e);
      end
      if (!m_vis && mq.size() > 0 && mq[0].earliest <= edge_n) m_vis = 1'b1;
    end
  end

  // Compare every output against the model in mid-cycle.
  always @(negedge clk) begin : cmp
    bit tk;
    int fcnt;
    tk   = bus.alloc_take && m_vis;
    fcnt = mq.size() - int'(m_vis);
    check("alloc_valid", int'(bus.alloc_valid), int'(m_vis));
    check("alloc_tag", int'(bus.alloc_tag), m_vis ? int'(mq[0].tag) : 0);
    check("free_count", int'(bus.free_count), mq.size());
    check("fifo_ren", int'(bus.fifo_ren), int'((!m_vis || tk) && fcnt > 0));
    check("fifo_wen", int'(bus.fifo_wen), int'(m_rel_ok()));
    check("fifo_din", int'(bus.fifo_din), int'(bus.release_tag));
    check("err_release", int'(bus.err_release), int'(m_err));
    check("err_sticky", int'(bus.err_sticky), int'(m_sticky));
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    bus.alloc_take = 1'b0;
    bus.release_valid = 1'b0;
    bus.release_tag = '0;
    adv();
    adv();
    resetn = 1'b1;
    settle();
  endtask

  initial begin
    int used[$];
    int r;
    bus.alloc_take = 1'b0;
    bus.release_valid = 1'b0;
    bus.release_tag = '0;
    #1 resetn = 1'b0;

    // Reset state and back-to-back drain of all tags.
    settle();
    check("rst_alloc_valid", int'(bus.alloc_valid), 0);
    check("rst_free_count", int'(bus.free_count), 16);
    check("rst_err_sticky", int'(bus.err_sticky), 0);
    adv();
    resetn = 1'b1;
    bus.alloc_take = 1'b1;
    settle();
    check("first_fifo_ren", int'(bus.fifo_ren), 1);
    check("first_alloc_valid", int'(bus.alloc_valid), 0);
    for (int i = 0; i < 16; i++) begin
      adv();
      settle();
      check("drain_valid", int'(bus.alloc_valid), 1);
      check("drain_tag", int'(bus.alloc_tag), i);
    end
    adv();
    settle();
    check("empty_valid", int'(bus.alloc_valid), 0);
    check("empty_free_count", int'(bus.free_count), 0);
    check("empty_fifo_ren", int'(bus.fifo_ren), 0);
    bus.alloc_take = 1'b0;

    // Release into an empty pool: reappears two edges later.
    bus.release_valid = 1'b1;
    bus.release_tag = TW'(5);
    #1;
    check("rel5_wen", int'(bus.fifo_wen), 1);
    check("rel5_din", int'(bus.fifo_din), 5);
    adv();
    bus.release_valid = 1'b0;
    settle();
    check("rel5_free_count", int'(bus.free_count), 1);
    check("rel5_not_yet", int'(bus.alloc_valid), 0);
    adv();
    settle();
    check("rel5_valid", int'(bus.alloc_valid), 1);
    check("rel5_tag", int'(bus.alloc_tag), 5);

    // Double release of tag 0.
    bus.release_valid = 1'b1;
    bus.release_tag = TW'(0);
    #1;
    check("dbl_first_wen", int'(bus.fifo_wen), 1);
    adv();
    settle();
    check("dbl_second_wen", int'(bus.fifo_wen), 0);
    adv();
    bus.release_valid = 1'b0;
    settle();
    check("dbl_err_release", int'(bus.err_release), 1);
    check("dbl_err_sticky", int'(bus.err_sticky), 1);
    adv();
    settle();
    check("dbl_err_pulse_end", int'(bus.err_release), 0);
    check("dbl_err_sticky_hold", int'(bus.err_sticky), 1);

    // Never-taken tag and out-of-range tag.
    do_reset();
    bus.release_valid = 1'b1;
    bus.release_tag = TW'(3);
    #1;
    check("rel3_wen", int'(bus.fifo_wen), 0);
    adv();
    bus.release_tag = TW'(20);
    settle();
    check("rel20_wen", int'(bus.fifo_wen), 0);
    check("rel3_err", int'(bus.err_release), 1);
    adv();
    bus.release_valid = 1'b0;
    settle();
    check("bad_rel_free_count", int'(bus.free_count), 16);
    check("bad_rel_sticky", int'(bus.err_sticky), 1);

    // Take and legal release in the same cycle.
    bus.alloc_take = 1'b1;
    adv(); adv(); adv();
    bus.release_valid = 1'b1;
    bus.release_tag = TW'(1);
    settle();
    check("both_ren", int'(bus.fifo_ren), 1);
    check("both_wen", int'(bus.fifo_wen), 1);
    check("both_tag", int'(bus.alloc_tag), 3);
    check("both_cnt_before", int'(bus.free_count), 13);
    adv();
    bus.release_valid = 1'b0;
    settle();
    check("both_cnt_after", int'(bus.free_count), 13);
    check("both_next_tag", int'(bus.alloc_tag), 4);
    for (int k = 5; k < 16; k++) begin
      adv();
      settle();
      check("queue_order_tag", int'(bus.alloc_tag), k);
    end
    adv();
    settle();
    check("requeued_valid", int'(bus.alloc_valid), 1);
    check("requeued_tag", int'(bus.alloc_tag), 1);
    bus.alloc_take = 1'b0;

    // Asynchronous reset with 7 tags allocated.
    do_reset();
    bus.alloc_take = 1'b1;
    bus.release_valid = 1'b1;
    bus.release_tag = TW'(20);
    adv();
    bus.release_valid = 1'b0;
    repeat (7) adv();
    settle();
    check("mid_free_count", int'(bus.free_count), 9);
    check("mid_tag", int'(bus.alloc_tag), 7);
    check("mid_sticky", int'(bus.err_sticky), 1);
    resetn = 1'b0;
    bus.alloc_take = 1'b0;
    #1;
    check("arst_valid", int'(bus.alloc_valid), 0);
    check("arst_free_count", int'(bus.free_count), 16);
    check("arst_sticky", int'(bus.err_sticky), 0);
    check("arst_err_release", int'(bus.err_release), 0);
    adv();
    resetn = 1'b1;
    adv();
    settle();
    check("restart_valid", int'(bus.alloc_valid), 1);
    check("restart_tag", int'(bus.alloc_tag), 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      settle();
      if ($urandom_range(0, 499) == 0) begin
        resetn = 1'b0;
        bus.alloc_take = 1'b0;
        bus.release_valid = 1'b0;
        adv();
        resetn = 1'b1;
        continue;
      end
      bus.alloc_take = ($urandom_range(0, 99) < 55);
      bus.release_valid = ($urandom_range(0, 99) < 45);
      used.delete();
      for (int i = 0; i < TC; i++) if (m_used[i]) used.push_back(i);
      r = int'($urandom_range(0, 99));
      if (r < 75 && used.size() > 0)
        bus.release_tag = TW'(used[$urandom_range(0, used.size() - 1)]);
      else if (r < 92)
        bus.release_tag = TW'($urandom_range(0, TC - 1));
      else
        bus.release_tag = TW'($urandom_range(TC, 63));
    end
    settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
